// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling FSM and a
// one-entry output holding register with valid/ready hand-off.
module uart_rx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o,
    output logic [2:0] state_o
);
    // Handshake: a byte moves out on every rising clk edge where valid_o and
    // ready_i are both high; data_o is held stable while valid_o is high.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            meta_q, meta_d;
    logic            rx_s_q, rx_s_d;
    logic [1:0]      settle_q, settle_d;
    logic            armed_q, armed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            busy_q, busy_d;
    logic            consume;

    assign consume = valid_q & ready_i;

    always_comb begin
        state_d     = state_q;
        meta_d      = rx_i;
        rx_s_d      = meta_q;
        settle_d    = {settle_q[0], 1'b1};
        // The line must be seen high (after the synchronizer has refilled
        // post-reset) before a falling edge may start a frame.
        armed_d     = armed_q | (settle_q[1] & rx_s_q);
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~consume;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (!valid_q || consume) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HI: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            meta_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= meta_d;
            rx_s_q      <= rx_s_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frame driver, random consumer, scoreboard of
// expected bytes popped by a negedge monitor, plus error-pulse bookkeeping.
module tb_uart_rx;
    localparam int CPB = 100;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
    int ready_mode = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o), .busy_o(busy_o), .state_o(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- drivers ----------------
    // mode 0: ready low, 1: ready high, 2: random ready (~75% high)
    initial forever begin
        @(posedge clk);
        #3;
        case (ready_mode)
            0:       ready_i = 1'b0;
            1:       ready_i = 1'b1;
            default: ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Caller is aligned at posedge+2; each bit lasts blen clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int blen);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            cyc(blen);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       v_prev, r_prev, fe_prev, ov_prev;
    logic [7:0] d_prev, e_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            v_prev = 1'b0; r_prev = 1'b0; fe_prev = 1'b0; ov_prev = 1'b0; d_prev = 8'h00;
        end else begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", data_o);
                end else begin
                    e_byte = exp_q.pop_front();
                    chk("rx_byte", {24'h0, data_o}, {24'h0, e_byte});
                end
            end
            if (v_prev && !r_prev && valid_o) chk("hold_stable", {24'h0, data_o}, {24'h0, d_prev});
            if (frame_err_o) begin
                fe_cnt++;
                chk("frame_err_single_cycle", {31'h0, fe_prev}, 32'h0);
            end
            if (overrun_o) begin
                ov_cnt++;
                chk("overrun_single_cycle", {31'h0, ov_prev}, 32'h0);
            end
            v_prev = valid_o; r_prev = ready_i; fe_prev = frame_err_o;
            ov_prev = overrun_o; d_prev = data_o;
        end
    end

    // Drain with ready high, then reconcile the scoreboard and pulse counts.
    task automatic end_phase(input string name);
        int k;
        ready_mode = 1;
        for (k = 0; k < 4000; k++) begin
            cyc(1);
            if (exp_q.size() == 0 && !busy_o && !valid_o) break;
        end
        cyc(5);
        chk({name, "_pending_bytes"}, exp_q.size(), 0);
        chk({name, "_frame_err_count"}, fe_cnt, exp_fe);
        chk({name, "_overrun_count"}, ov_cnt, exp_ov);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, hi, k, seen_busy, drop_k, blen, gap;
        logic [7:0] b;

        @(negedge clk);
        chk("reset_outputs", {20'h0, data_o, valid_o, frame_err_o, overrun_o, busy_o}, 32'h0);
        cyc(5);
        rst_n = 1'b1;
        cyc(20);

        // Single byte, immediate consumer: latency and one-cycle valid.
        ready_mode = 1;
        exp_q.push_back(8'h41);
        lat = -1;
        hi = 0;
        fork
            send_frame(8'h41, 1'b1, CPB);
            begin
                for (k = 1; k <= LAT + 20; k++) begin
                    @(negedge clk);
                    if (valid_o) begin
                        lat = k - 1;
                        break;
                    end
                end
                if (lat >= 0) begin
                    hi = 1;
                    for (int j = 0; j < 10; j++) begin
                        @(negedge clk);
                        if (valid_o) hi++;
                        else break;
                    end
                end
            end
        join
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT);
        end
        chk("valid_one_cycle", hi, 1);
        end_phase("single");

        // Holding register full: second byte dropped with an overrun pulse.
        ready_mode = 0;
        cyc(1);
        exp_q.push_back(8'h52);
        exp_ov++;
        send_frame(8'h52, 1'b1, CPB);
        send_frame(8'hA5, 1'b1, CPB);
        cyc(5);
        chk("overrun_keeps_data", {24'h0, data_o}, 32'h52);
        chk("overrun_keeps_valid", {31'h0, valid_o}, 32'h1);
        chk("overrun_pulsed", ov_cnt, exp_ov);
        end_phase("overrun");

        // Consume in the exact stop-sample cycle of the next byte: no overrun.
        ready_mode = 0;
        cyc(1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        fork
            begin
                send_frame(8'h00, 1'b1, CPB);
                send_frame(8'hFF, 1'b1, CPB);
            end
            begin
                repeat (10 * CPB + LAT - 1) @(posedge clk);
                #2 ready_mode = 1;
                @(posedge clk);
                #2 ready_mode = 0;
                @(negedge clk);
                chk("simul_valid_stays", {31'h0, valid_o}, 32'h1);
                chk("simul_new_data", {24'h0, data_o}, 32'hFF);
            end
        join
        chk("simul_no_overrun", ov_cnt, exp_ov);
        end_phase("simul");

        // Stop bit low followed by a long break, then a clean byte.
        ready_mode = 1;
        exp_fe++;
        send_frame(8'h55, 1'b0, CPB);
        cyc(20 * CPB);
        rx_i = 1'b1;
        cyc(2 * CPB);
        chk("break_one_frame_err", fe_cnt, exp_fe);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, CPB);
        end_phase("break");

        // 300 ns glitch on an idle line.
        seen_busy = 0;
        drop_k = -1;
        fork
            begin
                rx_i = 1'b0;
                cyc(30);
                rx_i = 1'b1;
            end
            begin
                for (k = 1; k <= CPB / 2 + 20; k++) begin
                    @(negedge clk);
                    if (busy_o) seen_busy = 1;
                    else if (seen_busy != 0) begin
                        drop_k = k - 1;
                        break;
                    end
                end
            end
        join
        chk("glitch_seen_busy", seen_busy, 1);
        checks++;
        if (drop_k < 0 || drop_k > CPB / 2 + 3) begin
            errors++;
            $display("FAIL glitch_busy_drop: got %0d expected <= %0d", drop_k, CPB / 2 + 3);
        end
        end_phase("glitch");

        // Reset during bit 4 of 0x81, released while the line is low.
        fork
            send_frame(8'h81, 1'b1, CPB);
            begin
                cyc(5 * CPB + CPB / 2);
                rst_n = 1'b0;
                @(negedge clk);
                chk("mid_reset_outputs", {20'h0, data_o, valid_o, frame_err_o, overrun_o, busy_o}, 32'h0);
                cyc(4);
                rst_n = 1'b1;
            end
        join
        cyc(CPB);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, CPB);
        end_phase("reset");

        // Random bytes, +/-3% baud, random gaps (often none), random consumer.
        ready_mode = 2;
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom_range(0, 255));
            blen = $urandom_range(CPB * 97 / 100, CPB * 103 / 100);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3 * CPB);
            exp_q.push_back(b);
            send_frame(b, 1'b1, blen);
            if (gap > 0) cyc(gap);
        end
        end_phase("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(900000);
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
